// File: rtl/cache_mem_arbiter.sv
// Refill/writeback arbiter: grants the Icache, the Dcache or a Dcache writeback
// onto the single-ported memory bus and runs each grant as a line-sized burst.
module cache_mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned BEAT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_rreq_i,
  input  logic [31:0]       icache_raddr_i,
  output logic              icache_rvalid_o,
  output logic [31:0]       icache_rdata_o,
  output logic              icache_rdone_o,
  input  logic              dcache_rreq_i,
  input  logic [31:0]       dcache_raddr_i,
  output logic              dcache_rvalid_o,
  output logic [31:0]       dcache_rdata_o,
  output logic              dcache_rdone_o,
  input  logic              dcache_wreq_i,
  input  logic [31:0]       dcache_waddr_i,
  input  logic [31:0]       dcache_wdata_i,
  output logic [BEAT_W-1:0] dcache_wbeat_o,
  output logic              dcache_wnext_o,
  output logic              dcache_wdone_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned       OFF_W     = $clog2(LINE_WORDS) + 2;
  localparam logic [31:0]       LINE_MASK = 32'((1 << OFF_W) - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, RD_D, RD_I} state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       base_q, base_d;
  logic              last_rd_q, last_rd_d;  // 1: the Dcache got the most recent read grant
  logic              active;
  logic              beat_ack;
  logic              last_beat;

  assign active    = (state_q != IDLE);
  assign beat_ack  = active && mem_ack_i;
  assign last_beat = (cnt_q == LAST_BEAT);

  // Grant selection in IDLE, beat sequencing in the burst states
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dcache_wreq_i) begin
          state_d = WB;
          base_d  = dcache_waddr_i & ~LINE_MASK;
        end else if (dcache_rreq_i && (!icache_rreq_i || !last_rd_q)) begin
          state_d = RD_D;
          base_d  = dcache_raddr_i & ~LINE_MASK;
        end else if (icache_rreq_i) begin
          state_d = RD_I;
          base_d  = icache_raddr_i & ~LINE_MASK;
        end
      end
      default: begin
        if (beat_ack) begin
          cnt_d = cnt_q + BEAT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == RD_D) begin
              last_rd_d = 1'b1;
            end else if (state_q == RD_I) begin
              last_rd_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      last_rd_q <= last_rd_d;
    end
  end

  // Memory side is decoded from the state flops so it drops with reset immediately
  assign mem_req_o   = active;
  assign mem_we_o    = (state_q == WB);
  assign mem_addr_o  = base_q + (32'(cnt_q) << 2);
  assign mem_wdata_o = dcache_wdata_i;

  assign dcache_wbeat_o  = cnt_q;
  assign dcache_wnext_o  = beat_ack && (state_q == WB);
  assign dcache_wdone_o  = dcache_wnext_o && last_beat;
  assign dcache_rvalid_o = beat_ack && (state_q == RD_D);
  assign dcache_rdone_o  = dcache_rvalid_o && last_beat;
  assign icache_rvalid_o = beat_ack && (state_q == RD_I);
  assign icache_rdone_o  = icache_rvalid_o && last_beat;
  assign dcache_rdata_o  = mem_rdata_i;
  assign icache_rdata_o  = mem_rdata_i;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Refill/writeback arbiter between the Icache, the Dcache and the single-ported main-memory bus. It accepts line-refill requests from both caches and line-writeback requests from the Dcache. It grants one requester at a time and sequences each grant as a LINE_WORDS-beat burst of single-word handshakes on the memory side. It sits between `Icache`/`Dcache` and the memory model in the cache testbench.

## Interface
- LINE_WORDS, 4, words per cache line; power of two, 2..16
- BEAT_W, 4, width of beat index; must be ≥ log2(LINE_WORDS)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- icache_rreq_i  in  1  Icache refill request, level, held until done
- icache_raddr_i  in  32  Icache miss address
- icache_rvalid_o  out  1  refill word valid
- icache_rdata_o  out  32  refill word
- icache_rdone_o  out  1  refill complete, 1-cycle pulse
- dcache_rreq_i / dcache_raddr_i / dcache_rvalid_o / dcache_rdata_o / dcache_rdone_o  same as Icache set, for the Dcache
- dcache_wreq_i  in  1  Dcache writeback request, level, held until done
- dcache_waddr_i  in  32  victim line address
- dcache_wdata_i  in  32  word for beat dcache_wbeat_o
- dcache_wbeat_o  out  BEAT_W  current writeback beat index
- dcache_wnext_o  out  1  current beat accepted by memory
- dcache_wdone_o  out  1  writeback complete, 1-cycle pulse
- mem_req_o  out  1  memory access request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  word address
- mem_wdata_o  out  32  write data
- mem_ack_i  in  1  beat accepted (write) or mem_rdata_i valid (read)
- mem_rdata_i  in  32  read data

## Operation
- FSM states: IDLE, WB, RD_D, RD_I.
- IDLE: sample requests and pick a grant by the rules below.
  - dcache_wreq_i wins unconditionally. Writeback precedes the refill of the same miss.
  - Otherwise, if only one read request is pending, that requester is granted.
  - If both reads are pending, round-robin applies via flag last_rd. The requester not served last wins. last_rd resets to "I", so the first tie goes to the Dcache.
- On grant, latch base = addr with bits [log2(LINE_WORDS)+1:0] cleared. Clear beat counter cnt. Next state is WB, RD_D or RD_I.
- Active states:
  - mem_req_o = 1 and mem_addr_o = base + (cnt << 2).
  - mem_we_o = 1 only in WB.
  - mem_wdata_o = dcache_wdata_i, combinational pass-through.
  - dcache_wbeat_o = cnt.
- Beat completes on mem_ack_i = 1 while mem_req_o = 1:
  - cnt increments.
  - WB: dcache_wnext_o = 1.
  - RD_x: owner's rvalid_o = 1, and rdata_o = mem_rdata_i (combinational).
- On the beat where cnt = LINE_WORDS-1:
  - Owner's done_o = 1 in the same cycle.
  - Next state is IDLE.
  - last_rd updates for read grants.
- Requester obligations:
  - Deassert req at the edge where done_o is sampled high. The req is then low in the following IDLE cycle.
  - Hold addr stable while req is high.
- mem_ack_i is ignored when mem_req_o = 0.
- Non-owner rvalid/done outputs stay 0. rdata outputs of non-owners are don't-care (drive mem_rdata_i).
- Requests arriving mid-burst wait. Inputs are never dropped.

## Timing
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; cnt = 0; base = 0; last_rd = I.
  - All outputs are 0: mem_req_o, mem_we_o, all valid/next/done, and dcache_wbeat_o.
- Reset mid-burst aborts immediately. mem_req_o drops without waiting for the clock, and no done is issued. The requester re-requests after reset.
- Grant latency: a req high at edge k in IDLE produces mem_req_o = 1 from edge k+1.
- Zero-wait memory (ack same cycle as req): a line takes 1 IDLE cycle + LINE_WORDS beat cycles. Back-to-back grants are separated by exactly one IDLE cycle.
- Wait states: mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o stay stable until mem_ack_i.
- Address arithmetic: 32-bit. The line never crosses an alignment boundary, so there is no carry out of the offset bits.

## Test plan
- Reset: hold rst = 0 for 2 cycles with all requests high -> every output 0 and mem_req_o = 0; on release, the first grant is WB.
- Icache refill, icache_raddr_i = 0x1000_0014, ack every cycle, memory returns 0xC0..0xC3:
  - mem_addr_o sequence is 0x1000_0010, 14, 18, 1C with mem_we_o = 0.
  - Four icache_rvalid_o pulses deliver the data in order.
  - icache_rdone_o is high on the 4th beat.
- dcache_wreq_i (0x2000_0040, words 0xA0..A3) and dcache_rreq_i (0x3000_0000) asserted together:
  - Four writes at 0x2000_0040..4C occur first, with dcache_wbeat_o 0..3 and dcache_wdone_o on beat 3.
  - One IDLE cycle follows.
  - Four reads at 0x3000_0000..0C follow.
- Icache and Dcache reads held continuously for four transactions -> grant order is D, I, D, I, with one IDLE cycle between bursts.
- Memory inserts 2 wait cycles per beat on a Dcache refill -> each beat lasts 3 cycles with address stable, and dcache_rdone_o occurs on cycle 12 after the grant.
- Reset asserted after 2 beats of a WB -> mem_req_o drops asynchronously and no dcache_wdone_o is issued; the re-issued request restarts at beat 0 and base address.
